// File: rtl/subtrator_bcd_serial.sv
// Digit-serial BCD subtractor: diferenca = a - b - borrow_in over DIGITOS packed
// BCD digits, one digit per clock, least significant digit first.
// start/busy/done handshake (inicio/ocupado/pronto). The result registers are
// written as a whole on the edge into FIM and then hold until the next start.
module subtrator_bcd_serial #(
    parameter int DIGITOS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic [4*DIGITOS-1:0]   a,
    input  logic [4*DIGITOS-1:0]   b,
    input  logic                   borrow_in,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [4*DIGITOS-1:0]   diferenca,
    output logic                   borrow_out,
    output logic                   invalido
);

    localparam int W  = 4 * DIGITOS;
    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITOS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIM  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;          // minuend, shifted right one digit per step
    logic [W-1:0]  b_q, b_d;          // subtrahend, shifted alongside a_q
    logic          brw_q, brw_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  res_q, res_d;      // partial result, digits enter at the top
    logic          inv_q, inv_d;      // latched "some operand digit > 9"
    logic [W-1:0]  diferenca_q, diferenca_d;
    logic          borrow_out_q, borrow_out_d;
    logic          invalido_q, invalido_d;

    // Per-digit validity of the incoming operands, evaluated when a start is accepted
    logic [DIGITOS-1:0] dig_bad;
    generate
        for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_valid
            assign dig_bad[gi] = (a[gi*4 +: 4] > 4'd9) || (b[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    // One-digit subtract with borrow on the digit currently at the bottom of the shifters
    logic [4:0] t_diff;
    logic [3:0] t_digit;
    always_comb begin
        t_diff  = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'd0, brw_q};
        t_digit = t_diff[4] ? (t_diff[3:0] + 4'd10) : t_diff[3:0];
    end

    // Next-state and datapath control for IDLE -> CALC -> FIM -> IDLE
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        brw_d        = brw_q;
        idx_d        = idx_q;
        res_d        = res_q;
        inv_d        = inv_q;
        diferenca_d  = diferenca_q;
        borrow_out_d = borrow_out_q;
        invalido_d   = invalido_q;
        case (state_q)
            ST_IDLE: begin
                if (inicio) begin
                    a_d        = a;
                    b_d        = b;
                    brw_d      = borrow_in;
                    idx_d      = '0;
                    res_d      = '0;
                    inv_d      = |dig_bad;
                    invalido_d = 1'b0;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                brw_d = t_diff[4];
                res_d = (res_q >> 4) | (W'(t_digit) << (W - 4));
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    // Publish the full result at once; bad operands force a zero result
                    state_d      = ST_FIM;
                    diferenca_d  = inv_q ? '0 : res_d;
                    borrow_out_d = inv_q ? 1'b0 : t_diff[4];
                    invalido_d   = inv_q;
                end
            end
            ST_FIM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            brw_q        <= 1'b0;
            idx_q        <= '0;
            res_q        <= '0;
            inv_q        <= 1'b0;
            diferenca_q  <= '0;
            borrow_out_q <= 1'b0;
            invalido_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            brw_q        <= brw_d;
            idx_q        <= idx_d;
            res_q        <= res_d;
            inv_q        <= inv_d;
            diferenca_q  <= diferenca_d;
            borrow_out_q <= borrow_out_d;
            invalido_q   <= invalido_d;
        end
    end

    assign ocupado    = (state_q == ST_CALC);
    assign pronto     = (state_q == ST_FIM);
    assign diferenca  = diferenca_q;
    assign borrow_out = borrow_out_q;
    assign invalido   = invalido_q;

endmodule
